// File: rtl/tick_stopwatch.sv
// Tick-driven MM:SS stopwatch: BCD count advanced by rising edges of a tick square wave.
// Optional lap (frozen display) feature compiled in with `define TICK_STOPWATCH_LAP_EN.
module tick_stopwatch #(
    parameter int unsigned TICKS_PER_SEC = 1
) (
    input  logic        src_clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] disp_bcd,
    output logic        running,
    output logic        lap_held,
    output logic        wrap
);

    localparam logic [9:0] PRE_MAX = 10'(TICKS_PER_SEC - 1);

`ifdef TICK_STOPWATCH_LAP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2, LAP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;
`endif

    state_t      state, state_next;
    logic        tick_q;
    logic [9:0]  pre;
    logic [15:0] count, count_next;
    logic        carry_wrap;
    logic        tick_edge, counting, count_en, sec_step;
    logic        lap_latch;

    assign tick_edge = tick & ~tick_q;
`ifdef TICK_STOPWATCH_LAP_EN
    assign counting  = (state == RUN) || (state == LAP);
`else
    assign counting  = (state == RUN);
`endif
    // An edge still counts on the RUN->STOP (or LAP->STOP) cycle; clear always wins.
    assign count_en  = tick_edge & counting & ~clear;
    assign sec_step  = count_en & (pre == PRE_MAX);

    // BCD increment with full carry chain, evaluated every cycle.
    always_comb begin
        count_next = count;
        carry_wrap = 1'b0;
        if (count[3:0] != 4'd9) begin
            count_next[3:0] = count[3:0] + 4'd1;
        end else begin
            count_next[3:0] = 4'd0;
            if (count[7:4] != 4'd5) begin
                count_next[7:4] = count[7:4] + 4'd1;
            end else begin
                count_next[7:4] = 4'd0;
                if (count[11:8] != 4'd9) begin
                    count_next[11:8] = count[11:8] + 4'd1;
                end else begin
                    count_next[11:8] = 4'd0;
                    if (count[15:12] != 4'd5) begin
                        count_next[15:12] = count[15:12] + 4'd1;
                    end else begin
                        count_next[15:12] = 4'd0;
                        carry_wrap        = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        lap_latch  = 1'b0;
        if (clear) begin
            state_next = IDLE;
        end else if (start_stop) begin
            case (state)
                IDLE:    state_next = RUN;
                RUN:     state_next = STOP;
                STOP:    state_next = RUN;
                default: state_next = STOP;
            endcase
`ifdef TICK_STOPWATCH_LAP_EN
        end else if (lap) begin
            if (state == RUN) begin
                state_next = LAP;
                lap_latch  = 1'b1;
            end else if (state == LAP) begin
                state_next = RUN;
            end
`endif
        end
    end

    always_ff @(posedge src_clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            tick_q <= 1'b0;
            pre    <= 10'd0;
            count  <= 16'h0000;
            wrap   <= 1'b0;
        end else begin
            state  <= state_next;
            tick_q <= tick;
            wrap   <= sec_step & carry_wrap;
            if (clear) begin
                pre   <= 10'd0;
                count <= 16'h0000;
            end else if (count_en) begin
                if (sec_step) begin
                    pre   <= 10'd0;
                    count <= count_next;
                end else begin
                    pre <= pre + 10'd1;
                end
            end
        end
    end

`ifdef TICK_STOPWATCH_LAP_EN
    logic [15:0] lap_reg;

    // Latches the pre-increment count, so a coinciding edge lands only in the live count.
    always_ff @(posedge src_clk or negedge reset_n) begin
        if (!reset_n) begin
            lap_reg <= 16'h0000;
        end else if (clear) begin
            lap_reg <= 16'h0000;
        end else if (lap_latch) begin
            lap_reg <= count;
        end
    end

    assign disp_bcd = (state == LAP) ? lap_reg : count;
    assign running  = (state == RUN) || (state == LAP);
    assign lap_held = (state == LAP);
`else
    logic unused_lap;
    assign unused_lap = lap | lap_latch;
    assign disp_bcd   = count;
    assign running    = (state == RUN);
    assign lap_held   = 1'b0;
`endif

endmodule

// File: tb/tb_tick_stopwatch.sv
// Self-checking bench for tick_stopwatch: two instances (1 and 2 ticks/sec) on shared stimulus,
// a constant vector table, directed corner sequences and a random run against a seconds-level model.
module tb_tick_stopwatch;

    logic        src_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
    logic [15:0] d1_disp, d2_disp;
    logic        d1_run, d2_run, d1_lh, d2_lh, d1_wrap, d2_wrap;

    int passed = 0;
    int total  = 0;

`ifdef TICK_STOPWATCH_LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif
    localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_LAP = 3;

    tick_stopwatch #(.TICKS_PER_SEC(1)) u_tps1 (
        .src_clk(src_clk), .reset_n(reset_n), .tick(tick), .start_stop(start_stop),
        .clear(clear), .lap(lap), .disp_bcd(d1_disp), .running(d1_run),
        .lap_held(d1_lh), .wrap(d1_wrap));

    tick_stopwatch #(.TICKS_PER_SEC(2)) u_tps2 (
        .src_clk(src_clk), .reset_n(reset_n), .tick(tick), .start_stop(start_stop),
        .clear(clear), .lap(lap), .disp_bcd(d2_disp), .running(d2_run),
        .lap_held(d2_lh), .wrap(d2_wrap));

    always #5 src_clk = ~src_clk;

    // Reference model: whole seconds 0..3599 plus prescale count, per instance.
    int m_mode[2], m_tot[2], m_pre[2], m_lap[2];
    bit m_wrap[2];
    bit m_prev;

    function automatic logic [15:0] to_bcd(int tot);
        int m = tot / 60;
        int s = tot % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_reset();
        m_prev = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_IDLE; m_tot[i] = 0; m_pre[i] = 0; m_lap[i] = 0; m_wrap[i] = 1'b0;
        end
    endtask

    task automatic model_update(bit t, bit ss, bit cl, bit lp);
        bit e = t && !m_prev;
        m_prev = t;
        for (int i = 0; i < 2; i++) begin
            int tps = (i == 0) ? 1 : 2;
            int old = m_tot[i];
            bit cnt = (m_mode[i] == M_RUN) || (m_mode[i] == M_LAP);
            m_wrap[i] = 1'b0;
            if (cl) begin
                m_mode[i] = M_IDLE; m_tot[i] = 0; m_pre[i] = 0; m_lap[i] = 0;
            end else begin
                if (e && cnt) begin
                    m_pre[i]++;
                    if (m_pre[i] == tps) begin
                        m_pre[i] = 0;
                        m_tot[i] = (m_tot[i] + 1) % 3600;
                        if (m_tot[i] == 0) m_wrap[i] = 1'b1;
                    end
                end
                if (ss) begin
                    m_mode[i] = (m_mode[i] == M_IDLE || m_mode[i] == M_STOP) ? M_RUN : M_STOP;
                end else if (lp && LAP_ON) begin
                    if (m_mode[i] == M_RUN) begin
                        m_mode[i] = M_LAP;
                        m_lap[i]  = old;
                    end else if (m_mode[i] == M_LAP) begin
                        m_mode[i] = M_RUN;
                    end
                end
            end
        end
    endtask

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_model(string name);
        for (int i = 0; i < 2; i++) begin
            logic [15:0] disp = (i == 0) ? d1_disp : d2_disp;
            logic        run  = (i == 0) ? d1_run  : d2_run;
            logic        lh   = (i == 0) ? d1_lh   : d2_lh;
            logic        wr   = (i == 0) ? d1_wrap : d2_wrap;
            chk($sformatf("%s.u%0d.disp", name, i + 1), disp,
                to_bcd(m_mode[i] == M_LAP ? m_lap[i] : m_tot[i]));
            chk($sformatf("%s.u%0d.running", name, i + 1), 16'(run),
                16'(m_mode[i] == M_RUN || m_mode[i] == M_LAP));
            chk($sformatf("%s.u%0d.lap_held", name, i + 1), 16'(lh), 16'(m_mode[i] == M_LAP));
            chk($sformatf("%s.u%0d.wrap", name, i + 1), 16'(wr), 16'(m_wrap[i]));
        end
    endtask

    // One clock: drive at the falling edge, model on the rising edge, leave outputs settled.
    task automatic step(bit t, bit ss = 0, bit cl = 0, bit lp = 0);
        @(negedge src_clk);
        tick = t; start_stop = ss; clear = cl; lap = lp;
        @(posedge src_clk);
        model_update(t, ss, cl, lp);
        #1;
        start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    endtask

    task automatic edges(int n);
        for (int k = 0; k < n; k++) begin
            step(0);
            step(1);
        end
    endtask

    typedef struct {
        bit          t, ss, cl, lp;
        logic [15:0] exp_disp;
        bit          exp_run, exp_lh, exp_wrap;
    } vec_t;
    vec_t vec[14];

    initial begin
        vec[0]  = '{0, 1, 0, 0, 16'h0000, 1, 0, 0};
        vec[1]  = '{1, 0, 0, 0, 16'h0001, 1, 0, 0};
        vec[2]  = '{0, 0, 0, 0, 16'h0001, 1, 0, 0};
        vec[3]  = '{1, 0, 0, 0, 16'h0002, 1, 0, 0};
        vec[4]  = '{0, 1, 0, 0, 16'h0002, 0, 0, 0};
        vec[5]  = '{1, 0, 0, 0, 16'h0002, 0, 0, 0};
        vec[6]  = '{0, 1, 0, 0, 16'h0002, 1, 0, 0};
        vec[7]  = '{1, 1, 0, 0, 16'h0003, 0, 0, 0};
        vec[8]  = '{0, 0, 0, 0, 16'h0003, 0, 0, 0};
        vec[9]  = '{1, 1, 0, 0, 16'h0003, 1, 0, 0};
        vec[10] = '{0, 0, 0, 0, 16'h0003, 1, 0, 0};
        vec[11] = '{1, 0, 1, 0, 16'h0000, 0, 0, 0};
        vec[12] = '{0, 0, 0, 1, 16'h0000, 0, 0, 0};
        vec[13] = '{1, 0, 0, 0, 16'h0000, 0, 0, 0};

        model_reset();
        repeat (3) @(posedge src_clk);
        #1;
        chk("reset.disp", d1_disp, 16'h0000);
        chk("reset.running", 16'(d1_run), 16'h0);
        chk("reset.wrap", 16'(d1_wrap), 16'h0);
        @(negedge src_clk);
        reset_n = 1'b1;

        // Vector table (1 tick/sec instance)
        for (int v = 0; v < 14; v++) begin
            step(vec[v].t, vec[v].ss, vec[v].cl, vec[v].lp);
            chk($sformatf("vec%0d.disp", v), d1_disp, vec[v].exp_disp);
            chk($sformatf("vec%0d.running", v), 16'(d1_run), 16'(vec[v].exp_run));
            chk($sformatf("vec%0d.lap_held", v), 16'(d1_lh), 16'(vec[v].exp_lh));
            chk($sformatf("vec%0d.wrap", v), 16'(d1_wrap), 16'(vec[v].exp_wrap));
        end
        check_model("after_table");

        // Basic counting and prescaler
        step(0, 0, 1);
        step(0, 1);
        edges(5);
        chk("basic.disp", d1_disp, 16'h0005);
        chk("basic.running", 16'(d1_run), 16'h1);
        check_model("basic");
        step(0, 0, 1);
        step(0, 1);
        edges(7);
        chk("pre.disp7", d2_disp, 16'h0003);
        edges(1);
        chk("pre.disp8", d2_disp, 16'h0004);
        check_model("pre");

        // Wrap 59:59 -> 00:00
        step(0, 0, 1);
        step(0, 1);
        edges(3599);
        chk("wrap.pre_disp", d1_disp, 16'h5959);
        chk("wrap.pre_wrap", 16'(d1_wrap), 16'h0);
        edges(1);
        chk("wrap.disp", d1_disp, 16'h0000);
        chk("wrap.pulse", 16'(d1_wrap), 16'h1);
        chk("wrap.running", 16'(d1_run), 16'h1);
        check_model("wrap");
        step(0);
        chk("wrap.one_cycle", 16'(d1_wrap), 16'h0);

        // Lap freeze / unfreeze, or lap ignored in the default build
        step(0, 0, 1);
        step(0, 1);
        edges(12);
        step(0, 0, 0, 1);
`ifdef TICK_STOPWATCH_LAP_EN
        edges(3);
        chk("lap.frozen", d1_disp, 16'h0012);
        chk("lap.held", 16'(d1_lh), 16'h1);
        step(1, 0, 0, 1);
        chk("lap.live", d1_disp, 16'h0015);
        chk("lap.released", 16'(d1_lh), 16'h0);
        step(0);
        step(1, 0, 0, 1);
        chk("lap.coincide_latch", d1_disp, 16'h0015);
        step(0, 0, 0, 1);
        chk("lap.coincide_live", d1_disp, 16'h0016);
        check_model("lap");
`else
        chk("nolap.held", 16'(d1_lh), 16'h0);
        edges(1);
        chk("nolap.live", d1_disp, 16'h0013);
        check_model("nolap");
`endif

        // clear + start_stop + edge together
        step(0, 0, 1);
        step(0, 1);
        edges(30);
        chk("simul.pre", d1_disp, 16'h0030);
        step(0);
        step(1, 1, 1);
        chk("simul.disp", d1_disp, 16'h0000);
        chk("simul.running", 16'(d1_run), 16'h0);
        step(0, 1);
        step(1);
        chk("simul.resume", d1_disp, 16'h0001);
        check_model("simul");

        // Asynchronous reset mid-run
        step(0, 0, 1);
        step(0, 1);
        edges(127);
        chk("rst.pre", d1_disp, 16'h0207);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_model("rst.async");
        @(negedge src_clk);
        reset_n = 1'b1;
        step(1);
        edges(3);
        chk("rst.ignored", d1_disp, 16'h0000);
        check_model("rst.idle");
        step(0, 1);
        step(1);
        chk("rst.restart", d1_disp, 16'h0001);

        // Random stimulus against the model
        step(0, 1);
        for (int r = 0; r < 800; r++) begin
            step(1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 60) == 0, $urandom_range(0, 7) == 0);
            check_model($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tick_stopwatch.md
TICK_STOPWATCH -- requirements
Module: tick_stopwatch

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 1: number of tick rising edges per one-second increment (legal range 1..1023).
REQ-002 SHALL have port src_clk, input, 1 bit: single clock; all state on rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port tick, input, 1 bit: gen_tick output (square wave, synchronous to src_clk).
REQ-005 SHALL have port start_stop, input, 1 bit: one-cycle pulse that toggles run/stop.
REQ-006 SHALL have port clear, input, 1 bit: one-cycle pulse that zeroes the count and stops.
REQ-007 SHALL have port lap, input, 1 bit: one-cycle pulse that freezes or unfreezes the display while counting continues.
REQ-008 SHALL have port disp_bcd, output, 16 bits: {min_tens, min_ones, sec_tens, sec_ones} BCD.
REQ-009 SHALL have port running, output, 1 bit: high in RUN or LAP.
REQ-010 SHALL have port lap_held, output, 1 bit: high in LAP.
REQ-011 SHALL have port wrap, output, 1 bit: one-cycle pulse on 59:59 -> 00:00.

Function
REQ-012 SHALL register tick into tick_q; an edge occurs at a src_clk rising edge where tick=1 and tick_q=0.
REQ-013 SHALL increment prescale counter pre (0..TICKS_PER_SEC-1) on each edge only in RUN/LAP; at pre=TICKS_PER_SEC-1 with an edge, pre->0 and seconds +1 at that same clock edge.
REQ-014 SHALL count BCD: sec_ones 0-9, sec_tens 0-5, min_ones 0-9, min_tens 0-5, with carry in the same cycle; 59:59 +1 -> 00:00 and wrap=1 for exactly that cycle.
REQ-015 SHALL implement states IDLE (count 0, stopped), RUN, STOP (paused, count held), LAP (counting, display frozen).
REQ-016 SHALL transition on start_stop: IDLE->RUN; RUN->STOP; STOP->RUN; LAP->STOP (display returns to live count).
REQ-017 SHALL transition on lap: RUN->LAP (latch live count into lap register); LAP->RUN; lap ignored in IDLE/STOP.
REQ-018 SHALL transition on clear from any state to IDLE, with count, pre and lap register zeroed.
REQ-019 SHALL apply priority clear > start_stop > lap when pulses coincide.
REQ-020 SHALL drive disp_bcd from the lap register in LAP, otherwise from the live count.
REQ-021 SHALL count an edge coinciding with start_stop in RUN (RUN->STOP) and SHALL NOT count an edge coinciding with start_stop in IDLE/STOP; SHALL NOT count an edge coinciding with clear.
REQ-022 SHALL NOT produce a missed or double count when a tick edge and a lap pulse coincide; the latched lap value is the pre-increment count.
REQ-023 SHALL keep tick_q updating in all states, so an edge is never invented when leaving STOP/IDLE.

Reset
REQ-024 SHALL, while reset_n=0, force state=IDLE, count=00:00, pre=0, lap register=0, tick_q=0, disp_bcd=16'h0000, running=0, lap_held=0, wrap=0.
REQ-025 SHALL abort any operation when reset is asserted mid-count, with no wrap pulse; the first edge after release is judged against tick_q=0.

Configuration
REQ-026 SHALL compile the lap feature only when macro TICK_STOPWATCH_LAP_EN is defined.
REQ-027 SHALL, without TICK_STOPWATCH_LAP_EN, omit the LAP state and lap register, ignore lap, tie lap_held to 0, and always drive disp_bcd from the live count.

Verification
REQ-028 SHALL cover basic counting: TICKS_PER_SEC=1, reset, start_stop, 5 tick edges -> disp_bcd=16'h0005, running=1.
REQ-029 SHALL cover the prescaler: TICKS_PER_SEC=2, run, 7 edges -> disp_bcd=16'h0003, pre=1; a further edge -> 16'h0004.
REQ-030 SHALL cover wrap: run to 59:59 (16'h5959), 1 edge -> 16'h0000, wrap high for exactly 1 cycle, running=1.
REQ-031 SHALL cover lap (macro on): at 00:12 pulse lap, 3 edges -> disp_bcd=16'h0012, lap_held=1; pulse lap -> 16'h0015, lap_held=0.
REQ-032 SHALL cover simultaneous pulses: clear + start_stop + edge in RUN at 00:30 -> IDLE, 16'h0000, running=0; next start_stop resumes counting from 00:00.
REQ-033 SHALL cover reset mid-run: reset_n low at 02:07 in RUN -> all outputs 0 asynchronously; edges after release are ignored until start_stop.
